guess_sequencer: RTL and testbench
==================================

Name: guess_sequencer

Overview:
- Game-level controller that owns the guess-entry and history-browse sequencing for the four-LED RGB display path.
- Turns debounced single-cycle button pulses into cursor, colour, submit and history-navigation actions.
- Drives the led_driver inputs: blink_enable, blink_led, guess_rgb0..3 and history_rgb0..3.
- Stores submitted guesses and emits each one to the scoring logic.

Parameters:
- NUM_COLORS, 6: number of usable colour codes (1..NUM_COLORS); code 0 = LED off. Legal range 2..7.
- MAX_GUESSES, 8: history depth and guess limit. Legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- btn_left  input  1  one-cycle pulse: cursor left (EDIT) or older entry (HISTORY/DONE)
- btn_right  input  1  one-cycle pulse: cursor right (EDIT) or newer entry (HISTORY/DONE)
- btn_color  input  1  one-cycle pulse: advance colour at cursor
- btn_submit  input  1  one-cycle pulse: commit current guess
- btn_hist  input  1  one-cycle pulse: toggle between EDIT and HISTORY
- game_won  input  1  pulse from scorer: force DONE
- blink_enable  output  1  1 only in EDIT
- blink_led  output  2  cursor position, 0..3
- guess_rgb0..guess_rgb3  output  3 each  current guess colours
- history_rgb0..history_rgb3  output  3 each  selected history entry; 0 in EDIT
- show_history  output  1  1 in HISTORY and DONE
- guess_count  output  4  number of committed guesses
- hist_idx  output  4  selected history entry
- guess_valid  output  1  one-cycle strobe accompanying guess_word
- guess_word  output  12  committed guess {rgb3,rgb2,rgb1,rgb0}
- game_over  output  1  1 in DONE

Behaviour:
- All outputs registered; a button pulse sampled on edge N is reflected after edge N.
- Reset values:
  - state = EDIT, blink_enable = 1, blink_led = 0
  - guess_rgb0..3 = 1; history outputs = 0
  - show_history = 0, guess_count = 0, hist_idx = 0
  - guess_valid = 0, guess_word = 0, game_over = 0
  - history memory contents don't care (unreadable until written)
- Button priority within one cycle (highest first): game_won > btn_submit > btn_hist > btn_color > btn_right > btn_left. Exactly one action per cycle; lower-priority pulses that cycle are dropped.
- EDIT:
  - btn_left: blink_led - 1, 0 wraps to 3.
  - btn_right: blink_led + 1, 3 wraps to 0.
  - btn_color: colour at cursor + 1; NUM_COLORS wraps to 1; never 0.
  - btn_submit:
    - Write the guess to history[guess_count] and put it on guess_word with guess_valid = 1 for exactly one cycle.
    - guess_count + 1; blink_led = 0; guess colours retained.
    - If the new guess_count == MAX_GUESSES, go to DONE.
  - btn_hist:
    - If guess_count > 0, go to HISTORY with hist_idx = guess_count - 1.
    - If guess_count == 0, ignore.
- HISTORY:
  - btn_left: hist_idx - 1, saturating at 0.
  - btn_right: hist_idx + 1, saturating at guess_count - 1.
  - btn_hist: return to EDIT; blink_led unchanged.
  - btn_color and btn_submit ignored.
- DONE:
  - Left/right browse as in HISTORY; all other buttons ignored.
  - Only rst exits DONE.
  - On entry, hist_idx = guess_count - 1, or 0 if guess_count == 0.
- game_won:
  - In EDIT or HISTORY, go to DONE next cycle.
  - If it coincides with btn_submit, the submit is dropped (no guess_valid).
- history_rgb0..3 = the entry at hist_idx while show_history = 1, else 0.
- rst asserted in any state, including the same cycle as any button, wins and restores all reset values; guess_count returns to 0 and history is considered empty.

Test Plan:
- Reset, then 4 btn_right pulses -> blink_led goes 1,2,3,0. Then btn_left -> blink_led = 3; blink_enable stays 1.
- Cursor at 2, 6 btn_color pulses (NUM_COLORS = 6) -> guess_rgb2 goes 2,3,4,5,6,1; other channels stay 1.
- Set guess {3,2,5,1}, btn_submit -> one-cycle guess_valid with guess_word = 12'b011_010_101_001, guess_count = 1, blink_led = 0.
- Three submits, btn_hist -> show_history = 1, hist_idx = 2. Then btn_left ×3 -> hist_idx 1,0,0. Then btn_right ×3 -> 1,2,2. history_rgb matches stored entries; btn_color ignored.
- MAX_GUESSES = 2: two submits -> game_over = 1, blink_enable = 0 after the second; later btn_submit gives no guess_valid. Then rst -> all reset values.
- btn_submit and game_won in the same cycle -> DONE, guess_valid stays 0, guess_count unchanged. btn_hist with guess_count = 0 -> state stays EDIT.

Source files
------------

// File: rtl/guess_sequencer.sv
// Guess-entry / history-browse sequencer for the four-LED RGB display path.
// Turns button pulses into cursor, colour, submit and history actions; every output is a flop.

module guess_lane #(
  parameter int NUM_COLORS = 6
) (
  input  logic [2:0] cur_i,
  output logic [2:0] nxt_o
);
  // Colour codes cycle 1..NUM_COLORS; code 0 (off) is never produced.
  assign nxt_o = (cur_i >= 3'(NUM_COLORS)) ? 3'd1 : cur_i + 3'd1;
endmodule

module guess_sequencer #(
  parameter int NUM_COLORS  = 6,
  parameter int MAX_GUESSES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_color,
  input  logic        btn_submit,
  input  logic        btn_hist,
  input  logic        game_won,
  output logic        blink_enable,
  output logic [1:0]  blink_led,
  output logic [2:0]  guess_rgb0,
  output logic [2:0]  guess_rgb1,
  output logic [2:0]  guess_rgb2,
  output logic [2:0]  guess_rgb3,
  output logic [2:0]  history_rgb0,
  output logic [2:0]  history_rgb1,
  output logic [2:0]  history_rgb2,
  output logic [2:0]  history_rgb3,
  output logic        show_history,
  output logic [3:0]  guess_count,
  output logic [3:0]  hist_idx,
  output logic        guess_valid,
  output logic [11:0] guess_word,
  output logic        game_over
);
  localparam int         NUM_LANES = 4;
  localparam logic [3:0] MAXG      = 4'(MAX_GUESSES);

  typedef enum logic [1:0] {S_EDIT, S_HIST, S_DONE} state_e;
  typedef enum logic [2:0] {A_NONE, A_WON, A_SUB, A_HST, A_COL, A_RIGHT, A_LEFT} act_e;

  state_e                          state_q, state_d;
  act_e                            act;
  logic [1:0]                      cur_q, cur_d;
  logic [NUM_LANES-1:0][2:0]       guess_q, guess_d, col_inc;
  logic [NUM_LANES-1:0][2:0]       hrgb_q, hrgb_d;
  logic [3:0]                      cnt_q, cnt_d, hidx_q, hidx_d;
  logic                            vld_q, vld_d;
  logic [11:0]                     word_q, word_d;
  logic                            be_q, sh_q, go_q;
  logic                            wr_en;
  logic [11:0]                     rd_word;
  logic [11:0]                     mem_q [16];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    guess_lane #(.NUM_COLORS(NUM_COLORS)) u_lane (
      .cur_i(guess_q[i]),
      .nxt_o(col_inc[i])
    );
  end

  // One action per cycle: the highest-priority pulse wins, even if the state ignores it.
  always_comb begin
    act = A_NONE;
    if      (game_won)   act = A_WON;
    else if (btn_submit) act = A_SUB;
    else if (btn_hist)   act = A_HST;
    else if (btn_color)  act = A_COL;
    else if (btn_right)  act = A_RIGHT;
    else if (btn_left)   act = A_LEFT;
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    guess_d = guess_q;
    cnt_d   = cnt_q;
    hidx_d  = hidx_q;
    vld_d   = 1'b0;
    word_d  = word_q;
    wr_en   = 1'b0;
    case (state_q)
      S_EDIT: begin
        case (act)
          A_WON: begin
            state_d = S_DONE;
            hidx_d  = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
          end
          A_SUB: begin
            wr_en  = 1'b1;
            vld_d  = 1'b1;
            word_d = guess_q;
            cnt_d  = cnt_q + 4'd1;
            cur_d  = 2'd0;
            if (cnt_q + 4'd1 == MAXG) begin
              state_d = S_DONE;
              hidx_d  = cnt_q;
            end
          end
          A_HST: begin
            if (cnt_q != 4'd0) begin
              state_d = S_HIST;
              hidx_d  = cnt_q - 4'd1;
            end
          end
          A_COL:   guess_d[cur_q] = col_inc[cur_q];
          A_RIGHT: cur_d = cur_q + 2'd1;
          A_LEFT:  cur_d = cur_q - 2'd1;
          default: ;
        endcase
      end
      S_HIST, S_DONE: begin
        case (act)
          A_WON: begin
            if (state_q == S_HIST) begin
              state_d = S_DONE;
              hidx_d  = cnt_q - 4'd1;
            end
          end
          A_HST:   if (state_q == S_HIST) state_d = S_EDIT;
          A_RIGHT: if (hidx_q + 4'd1 < cnt_q) hidx_d = hidx_q + 4'd1;
          A_LEFT:  if (hidx_q != 4'd0) hidx_d = hidx_q - 4'd1;
          default: ;
        endcase
      end
      default: state_d = S_EDIT;
    endcase

    // Bypass the entry being written so DONE-on-last-submit shows it immediately.
    rd_word = (wr_en && cnt_q == hidx_d) ? guess_q : mem_q[hidx_d];
    hrgb_d  = (state_d != S_EDIT && hidx_d < cnt_d) ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EDIT;
      cur_q   <= 2'd0;
      guess_q <= {NUM_LANES{3'd1}};
      cnt_q   <= 4'd0;
      hidx_q  <= 4'd0;
      vld_q   <= 1'b0;
      word_q  <= 12'd0;
      hrgb_q  <= '0;
      be_q    <= 1'b1;
      sh_q    <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      guess_q <= guess_d;
      cnt_q   <= cnt_d;
      hidx_q  <= hidx_d;
      vld_q   <= vld_d;
      word_q  <= word_d;
      hrgb_q  <= hrgb_d;
      be_q    <= (state_d == S_EDIT);
      sh_q    <= (state_d != S_EDIT);
      go_q    <= (state_d == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[cnt_q] <= guess_q;
  end

  assign blink_enable = be_q;
  assign blink_led    = cur_q;
  assign guess_rgb0   = guess_q[0];
  assign guess_rgb1   = guess_q[1];
  assign guess_rgb2   = guess_q[2];
  assign guess_rgb3   = guess_q[3];
  assign history_rgb0 = hrgb_q[0];
  assign history_rgb1 = hrgb_q[1];
  assign history_rgb2 = hrgb_q[2];
  assign history_rgb3 = hrgb_q[3];
  assign show_history = sh_q;
  assign guess_count  = cnt_q;
  assign hist_idx     = hidx_q;
  assign guess_valid  = vld_q;
  assign guess_word   = word_q;
  assign game_over    = go_q;
endmodule

// File: tb/tb_guess_sequencer.sv
// Bench for guess_sequencer: two instances (deep and shallow history) driven by the same
// directed + random button stream and compared against a behavioural game model.

module tb_guess_sequencer;
  localparam int NC = 6;
  localparam int RST = 0, WON = 1, SUB = 2, HST = 3, COL = 4, RT = 5, LF = 6;

  logic clk = 1'b0;
  logic rst = 1'b0, b_left = 1'b0, b_right = 1'b0, b_color = 1'b0;
  logic b_submit = 1'b0, b_hist = 1'b0, b_won = 1'b0;

  logic        be [2], sh [2], gv [2], go [2];
  logic [1:0]  bled [2];
  logic [2:0]  grgb [2][4];
  logic [2:0]  hrgb [2][4];
  logic [3:0]  gc [2], hi [2];
  logic [11:0] gwd [2];

  always #5 clk = ~clk;

  guess_sequencer #(.NUM_COLORS(NC), .MAX_GUESSES(8)) u_dut0 (
    .clk(clk), .rst(rst), .btn_left(b_left), .btn_right(b_right), .btn_color(b_color),
    .btn_submit(b_submit), .btn_hist(b_hist), .game_won(b_won),
    .blink_enable(be[0]), .blink_led(bled[0]),
    .guess_rgb0(grgb[0][0]), .guess_rgb1(grgb[0][1]), .guess_rgb2(grgb[0][2]), .guess_rgb3(grgb[0][3]),
    .history_rgb0(hrgb[0][0]), .history_rgb1(hrgb[0][1]), .history_rgb2(hrgb[0][2]), .history_rgb3(hrgb[0][3]),
    .show_history(sh[0]), .guess_count(gc[0]), .hist_idx(hi[0]),
    .guess_valid(gv[0]), .guess_word(gwd[0]), .game_over(go[0])
  );

  guess_sequencer #(.NUM_COLORS(NC), .MAX_GUESSES(2)) u_dut1 (
    .clk(clk), .rst(rst), .btn_left(b_left), .btn_right(b_right), .btn_color(b_color),
    .btn_submit(b_submit), .btn_hist(b_hist), .game_won(b_won),
    .blink_enable(be[1]), .blink_led(bled[1]),
    .guess_rgb0(grgb[1][0]), .guess_rgb1(grgb[1][1]), .guess_rgb2(grgb[1][2]), .guess_rgb3(grgb[1][3]),
    .history_rgb0(hrgb[1][0]), .history_rgb1(hrgb[1][1]), .history_rgb2(hrgb[1][2]), .history_rgb3(hrgb[1][3]),
    .show_history(sh[1]), .guess_count(gc[1]), .hist_idx(hi[1]),
    .guess_valid(gv[1]), .guess_word(gwd[1]), .game_over(go[1])
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: mode 0 = editing, 1 = browsing history, 2 = game over.
  int mode [2], cur [2], cnt [2], idx [2];
  int g [2][4];
  int hist [2][16];
  bit v [2];
  int w [2];
  int mx [2] = '{8, 2};

  task automatic mstep(input int k, input logic [6:0] b);
    v[k] = 1'b0;
    if (b[6-RST]) begin
      mode[k] = 0; cur[k] = 0; cnt[k] = 0; idx[k] = 0; w[k] = 0;
      for (int j = 0; j < 4; j++) g[k][j] = 1;
    end else if (b[6-WON]) begin
      if (mode[k] != 2) begin
        mode[k] = 2;
        idx[k] = (cnt[k] > 0) ? cnt[k] - 1 : 0;
      end
    end else if (b[6-SUB]) begin
      if (mode[k] == 0) begin
        w[k] = g[k][3] * 512 + g[k][2] * 64 + g[k][1] * 8 + g[k][0];
        hist[k][cnt[k]] = w[k];
        v[k] = 1'b1;
        cnt[k]++;
        cur[k] = 0;
        if (cnt[k] == mx[k]) begin
          mode[k] = 2;
          idx[k] = cnt[k] - 1;
        end
      end
    end else if (b[6-HST]) begin
      if (mode[k] == 0 && cnt[k] > 0) begin
        mode[k] = 1;
        idx[k] = cnt[k] - 1;
      end else if (mode[k] == 1) mode[k] = 0;
    end else if (b[6-COL]) begin
      if (mode[k] == 0) g[k][cur[k]] = g[k][cur[k]] % NC + 1;
    end else if (b[6-RT]) begin
      if (mode[k] == 0) cur[k] = (cur[k] + 1) % 4;
      else if (idx[k] < cnt[k] - 1) idx[k]++;
    end else if (b[6-LF]) begin
      if (mode[k] == 0) cur[k] = (cur[k] + 3) % 4;
      else if (idx[k] > 0) idx[k]--;
    end
  endtask

  task automatic cmp(input int k, input logic [6:0] b);
    chk($sformatf("blink_en%0d", k), be[k], mode[k] == 0);
    chk($sformatf("blink_led%0d", k), bled[k], cur[k]);
    chk($sformatf("show_hist%0d", k), sh[k], mode[k] != 0);
    chk($sformatf("game_over%0d", k), go[k], mode[k] == 2);
    chk($sformatf("count%0d", k), gc[k], cnt[k]);
    chk($sformatf("hist_idx%0d", k), hi[k], idx[k]);
    chk($sformatf("valid%0d", k), gv[k], v[k]);
    if (v[k] || b[6-RST]) chk($sformatf("word%0d", k), gwd[k], w[k]);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("guess%0d_%0d", k, j), grgb[k][j], g[k][j]);
      if (!(mode[k] != 0 && cnt[k] == 0))
        chk($sformatf("hist%0d_%0d", k, j), hrgb[k][j],
            (mode[k] != 0) ? (hist[k][idx[k]] >> (3 * j)) & 7 : 0);
    end
  endtask

  task automatic cyc(input logic [6:0] b);
    {rst, b_won, b_submit, b_hist, b_color, b_right, b_left} = b;
    @(posedge clk);
    for (int k = 0; k < 2; k++) mstep(k, b);
    #1;
    {rst, b_won, b_submit, b_hist, b_color, b_right, b_left} = '0;
    for (int k = 0; k < 2; k++) cmp(k, b);
  endtask

  task automatic press(input int which, input int n);
    logic [6:0] b;
    b = 7'b1000000 >> which;
    for (int i = 0; i < n; i++) cyc(b);
  endtask

  initial begin
    press(RST, 1);
    chk("rst_blink_en", be[0], 1);
    chk("rst_rgb0", grgb[0][0], 1);
    chk("rst_count", gc[0], 0);

    press(RT, 4);
    chk("cursor_wrap_r", bled[0], 0);
    press(LF, 1);
    chk("cursor_wrap_l", bled[0], 3);
    press(LF, 1);
    press(COL, 6);
    chk("colour_wrap", grgb[0][2], 1);

    // Build {3,2,5,1} from the reset colours and commit it.
    press(RST, 1);
    press(RT, 1); press(COL, 4);
    press(RT, 1); press(COL, 1);
    press(RT, 1); press(COL, 2);
    press(SUB, 1);
    chk("submit_word", gwd[0], 12'b011_010_101_001);
    chk("submit_valid", gv[0], 1);
    press(COL, 1);
    press(SUB, 2);
    chk("short_done", go[1], 1);
    press(HST, 1);
    chk("hist_entry_idx", hi[0], 2);
    press(LF, 3);
    press(RT, 3);
    press(COL, 1);
    press(HST, 1);
    press(SUB, 1);

    press(RST, 1);
    press(HST, 1);
    chk("hist_empty_edit", sh[0], 0);
    cyc(7'b0110000);
    chk("won_drops_submit", gv[0], 0);
    chk("won_done", go[0], 1);
    press(LF, 1);
    press(SUB, 1);

    press(RST, 1);
    for (int n = 0; n < 4000; n++) begin
      logic [6:0] b;
      b[6-RST] = ($urandom_range(0, 149) == 0);
      b[6-WON] = ($urandom_range(0, 199) == 0);
      for (int j = SUB; j <= LF; j++) b[6-j] = ($urandom_range(0, 4) == 0);
      cyc(b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
